// File: rtl/gtr_pkg.sv
// Shared definitions for the drive-mode sequencer: FSM states, mode encodings, command bit positions.
package gtr_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_ARMING = 3'd1,
    ST_IDLE   = 3'd2,
    ST_RUN    = 3'd3,
    ST_GUARD  = 3'd4
  } state_t;

  localparam logic [2:0] MODE_NONE = 3'b000;
  localparam logic [2:0] MODE_MAN  = 3'b001;
  localparam logic [2:0] MODE_SEMI = 3'b010;
  localparam logic [2:0] MODE_AUTO = 3'b100;

  // Bit positions inside a movement command {left, right, backward, forward}
  localparam int CMD_FWD   = 0;
  localparam int CMD_BACK  = 1;
  localparam int CMD_RIGHT = 2;
  localparam int CMD_LEFT  = 3;

  function automatic logic mode_is_valid(input logic [2:0] m);
    return (m == MODE_MAN) || (m == MODE_SEMI) || (m == MODE_AUTO);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable saturating down-counter; done is high whenever the count sits at zero.
module cycle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load has priority over counting; the count stops at zero instead of wrapping
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/drive_mode_sequencer.sv
// Power-up / mode-change sequencer: hold-to-arm power button, guarded mode switching,
// and arbitration of the per-mode movement requests onto a single registered command.
module drive_mode_sequencer
  import gtr_pkg::*;
#(
  parameter int HOLD_CYC  = 100_000_000,
  parameter int GUARD_CYC = 1_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       power_on,
  input  logic       power_off,
  input  logic       fault,
  input  logic [2:0] mode_signal,
  input  logic [3:0] man_cmd,
  input  logic [3:0] semi_cmd,
  input  logic [3:0] auto_cmd,
  output logic       power_on_led,
  output logic [2:0] mode_led,
  output logic [2:0] mode_grant,
  output logic [3:0] move_cmd,
  output logic       switching
);

  localparam int CNT_MAX = (HOLD_CYC > GUARD_CYC) ? HOLD_CYC : GUARD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // The OFF->ARMING edge already counts as the first held cycle, so the timer
  // covers the remaining HOLD_CYC-1 cycles and IDLE is reached on the HOLD_CYC-th.
  localparam logic [CNT_W-1:0] ARM_LOAD   = CNT_W'(HOLD_CYC - 2);
  // GUARD is entered with GUARD_CYC-1 loaded and exits on the edge that sees zero,
  // giving exactly GUARD_CYC cycles in GUARD.
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC - 1);

  state_t           state, state_nxt;
  logic [2:0]       target, target_nxt;
  logic             tmr_load, tmr_en, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  logic             stop_req;
  logic [3:0]       sel_cmd;
  logic [3:0]       move_cmd_p1;

  // Conflicting direction pairs cancel the whole command rather than favouring one side
  function automatic logic [3:0] cmd_sanitize(input logic [3:0] c);
    if ((c[CMD_LEFT] && c[CMD_RIGHT]) || (c[CMD_FWD] && c[CMD_BACK])) begin
      return 4'b0000;
    end
    return c;
  endfunction

  assign stop_req = power_off || fault;

  cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  // State and latched target mode registers
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state  <= ST_OFF;
      target <= MODE_NONE;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
    end
  end

  // Next-state, target latch and timer control
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    tmr_load   = 1'b0;
    tmr_val    = ARM_LOAD;
    tmr_en     = 1'b0;
    case (state)
      ST_OFF: begin
        if (power_on && !stop_req) begin
          state_nxt = ST_ARMING;
          tmr_load  = 1'b1;
          tmr_val   = ARM_LOAD;
        end
      end
      ST_ARMING: begin
        if (stop_req || !power_on) begin
          state_nxt = ST_OFF;
        end else if (tmr_done) begin
          state_nxt = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_IDLE: begin
        if (stop_req) begin
          state_nxt = ST_OFF;
        end else if (mode_is_valid(mode_signal)) begin
          state_nxt  = ST_GUARD;
          target_nxt = mode_signal;
          tmr_load   = 1'b1;
          tmr_val    = GUARD_LOAD;
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          state_nxt = ST_OFF;
        end else if (mode_signal != target) begin
          state_nxt  = ST_GUARD;
          target_nxt = mode_is_valid(mode_signal) ? mode_signal : MODE_NONE;
          tmr_load   = 1'b1;
          tmr_val    = GUARD_LOAD;
        end
      end
      ST_GUARD: begin
        if (stop_req) begin
          state_nxt = ST_OFF;
        end else if (tmr_done) begin
          state_nxt = (target != MODE_NONE) ? ST_RUN : ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_OFF;
      end
    endcase
    if (state_nxt == ST_OFF) begin
      target_nxt = MODE_NONE;
      tmr_load   = 1'b1;
      tmr_val    = '0;
    end
  end

  // Pick the movement request of the granted mode
  always_comb begin
    sel_cmd = 4'b0000;
    case (target)
      MODE_MAN:  sel_cmd = man_cmd;
      MODE_SEMI: sel_cmd = semi_cmd;
      MODE_AUTO: sel_cmd = auto_cmd;
      default:   sel_cmd = 4'b0000;
    endcase
  end

  // p1: registered movement command; blanked on the edge that leaves RUN so the
  // guard interval and shutdown never see a stale command
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      move_cmd_p1 <= 4'b0000;
    end else if ((state == ST_RUN) && (state_nxt == ST_RUN)) begin
      move_cmd_p1 <= cmd_sanitize(sel_cmd);
    end else begin
      move_cmd_p1 <= 4'b0000;
    end
  end

  assign move_cmd     = move_cmd_p1;
  assign power_on_led = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_GUARD);
  assign switching    = (state == ST_GUARD);
  assign mode_grant   = (state == ST_RUN) ? target : MODE_NONE;
  assign mode_led     = mode_grant;

endmodule

// File: tb/tb_drive_mode_sequencer.sv
// Scoreboard bench for drive_mode_sequencer with HOLD_CYC=10, GUARD_CYC=4.
module tb_drive_mode_sequencer;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       power_on, power_off, fault;
  logic [2:0] mode_signal;
  logic [3:0] man_cmd, semi_cmd, auto_cmd;
  logic       power_on_led, switching;
  logic [2:0] mode_led, mode_grant;
  logic [3:0] move_cmd;

  typedef struct {
    string      name;
    logic [11:0] exp;   // {led, mode_led, mode_grant, move_cmd, switching}
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  drive_mode_sequencer #(
    .HOLD_CYC  (10),
    .GUARD_CYC (4)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .power_on     (power_on),
    .power_off    (power_off),
    .fault        (fault),
    .mode_signal  (mode_signal),
    .man_cmd      (man_cmd),
    .semi_cmd     (semi_cmd),
    .auto_cmd     (auto_cmd),
    .power_on_led (power_on_led),
    .mode_led     (mode_led),
    .mode_grant   (mode_grant),
    .move_cmd     (move_cmd),
    .switching    (switching)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic led, input logic [2:0] ml,
                            input logic [3:0] mv, input logic sw);
    exp_t e;
    e.name = name;
    e.exp  = {led, ml, ml, mv, sw};
    q.push_back(e);
  endtask

  // Monitor: every falling edge, compare all pending expectations against the DUT
  always @(negedge sys_clk) begin
    exp_t        e;
    logic [11:0] act;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = {power_on_led, mode_led, mode_grant, move_cmd, switching};
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got led=%b mode_led=%b grant=%b move=%b sw=%b, expected led=%b mode_led=%b grant=%b move=%b sw=%b",
                 e.name, act[11], act[10:8], act[7:5], act[4:1], act[0],
                 e.exp[11], e.exp[10:8], e.exp[7:5], e.exp[4:1], e.exp[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; power_on = 1'b0; power_off = 1'b0; fault = 1'b0;
    mode_signal = 3'b000; man_cmd = 4'b0; semi_cmd = 4'b0; auto_cmd = 4'b0;
    tick(); tick();
    expect_out("reset", 1'b0, 3'b000, 4'b0000, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("post_reset_off", 1'b0, 3'b000, 4'b0000, 1'b0);

    // Hold 9 cycles then release: never powers up
    power_on = 1'b1;
    repeat (9) tick();
    expect_out("arm9_held", 1'b0, 3'b000, 4'b0000, 1'b0);
    power_on = 1'b0;
    tick();
    expect_out("arm9_release", 1'b0, 3'b000, 4'b0000, 1'b0);
    tick();
    expect_out("arm9_stay_off", 1'b0, 3'b000, 4'b0000, 1'b0);

    // Hold 10 cycles: powers up on the 10th edge
    power_on = 1'b1;
    repeat (9) tick();
    expect_out("arm10_pre", 1'b0, 3'b000, 4'b0000, 1'b0);
    tick();
    expect_out("arm10_done", 1'b1, 3'b000, 4'b0000, 1'b0);
    power_on = 1'b0;

    // Non-one-hot request keeps IDLE
    mode_signal = 3'b011;
    tick();
    expect_out("idle_invalid", 1'b1, 3'b000, 4'b0000, 1'b0);

    // IDLE -> manual through a 4-cycle guard
    mode_signal = 3'b001; man_cmd = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("guard_man_%0d", i), 1'b1, 3'b000, 4'b0000, 1'b1);
    end
    tick();
    expect_out("run_man_entry", 1'b1, 3'b001, 4'b0000, 1'b0);
    tick();
    expect_out("run_man_cmd", 1'b1, 3'b001, 4'b0001, 1'b0);

    // Manual -> auto: command blanked through the whole guard
    mode_signal = 3'b100; auto_cmd = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("guard_auto_%0d", i), 1'b1, 3'b000, 4'b0000, 1'b1);
    end
    tick();
    expect_out("run_auto_entry", 1'b1, 3'b100, 4'b0000, 1'b0);
    tick();
    expect_out("run_auto_cmd", 1'b1, 3'b100, 4'b1000, 1'b0);

    // Conflicting directions cancel; other modes' requests are not routed
    auto_cmd = 4'b1100; man_cmd = 4'b0010;
    tick();
    expect_out("cmd_left_right", 1'b1, 3'b100, 4'b0000, 1'b0);
    auto_cmd = 4'b0011;
    tick();
    expect_out("cmd_fwd_back", 1'b1, 3'b100, 4'b0000, 1'b0);
    auto_cmd = 4'b0101;
    tick();
    expect_out("cmd_right_fwd", 1'b1, 3'b100, 4'b0101, 1'b0);

    // Invalid request -> guard -> IDLE; a change during guard is picked up only after exit
    mode_signal = 3'b011; semi_cmd = 4'b0010;
    tick();
    expect_out("guard_none_0", 1'b1, 3'b000, 4'b0000, 1'b1);
    mode_signal = 3'b010;
    for (int i = 1; i < 4; i++) begin
      tick();
      expect_out($sformatf("guard_none_%0d", i), 1'b1, 3'b000, 4'b0000, 1'b1);
    end
    tick();
    expect_out("idle_after_none", 1'b1, 3'b000, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("guard_semi_%0d", i), 1'b1, 3'b000, 4'b0000, 1'b1);
    end
    tick();
    expect_out("run_semi_entry", 1'b1, 3'b010, 4'b0000, 1'b0);
    tick();
    expect_out("run_semi_cmd", 1'b1, 3'b010, 4'b0010, 1'b0);

    // One-cycle fault shuts everything down
    fault = 1'b1;
    tick();
    expect_out("fault_off", 1'b0, 3'b000, 4'b0000, 1'b0);
    fault = 1'b0;

    // power_off wins over power_on
    power_on = 1'b1; power_off = 1'b1;
    repeat (12) tick();
    expect_out("on_and_off", 1'b0, 3'b000, 4'b0000, 1'b0);
    power_on = 1'b0; power_off = 1'b0;

    // Re-power, enter guard, reset on its 2nd cycle
    power_on = 1'b1;
    repeat (10) tick();
    expect_out("repower", 1'b1, 3'b000, 4'b0000, 1'b0);
    power_on = 1'b0; mode_signal = 3'b001;
    tick();
    tick();
    expect_out("guard_before_rst", 1'b1, 3'b000, 4'b0000, 1'b1);
    rst = 1'b1;
    tick();
    expect_out("rst_in_guard", 1'b0, 3'b000, 4'b0000, 1'b0);
    rst = 1'b0;

    // A full hold is needed again after reset
    power_on = 1'b1;
    repeat (9) tick();
    expect_out("rearm9", 1'b0, 3'b000, 4'b0000, 1'b0);
    tick();
    expect_out("rearm10", 1'b1, 3'b000, 4'b0000, 1'b0);
    power_on = 1'b0; power_off = 1'b1;
    tick();
    expect_out("power_off_idle", 1'b0, 3'b000, 4'b0000, 1'b0);
    power_off = 1'b0;

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge sys_clk);
    #2;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
